// File: rtl/fft_power_peak_reader.sv
// FFT result consumer: per-bin |X|^2 for two channels, per-frame peak search,
// and a two-beat trailer (peaks, then frame count / status / peak bins).
module fft_power_peak_reader #(
    parameter int FFT_LEN            = 8192,
    parameter int FFT_AXI_DATA_WIDTH = 32,
    parameter int FFT_INDEX_LEN      = 32,
    parameter int PEAK_MIN_BIN       = 1
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [2*FFT_AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    input  logic [FFT_INDEX_LEN-1:0]        s_axis_index,
    output logic [63:0]                     m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    input  logic                            m_axis_tready,
    output logic                            frame_done,
    output logic [2:0]                      frame_status
);
    localparam int PWR_W  = FFT_AXI_DATA_WIDTH;
    localparam int HALF_W = FFT_AXI_DATA_WIDTH / 2;
    localparam int BIN_W  = $clog2(FFT_LEN);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);
    localparam logic [BIN_W-1:0] MIN_BIN  = BIN_W'(PEAK_MIN_BIN);

    typedef enum logic [1:0] {RUN, DRAIN, TRL_B} state_t;

    state_t state_q, state_d;

    logic                             en, accept, last_beat, at_last;
    logic                             trl_a_ld, trl_b_ld;
    logic [2:0]                       beat_flags, status_acc;
    logic [BIN_W-1:0]                 bin_cnt;
    logic [15:0]                      frame_cnt;
    logic                             vld_p1;
    logic [1:0][PWR_W-1:0]            re_sq_p1, im_sq_p1;
    logic [BIN_W-1:0]                 bin_p1;
    logic [1:0][PWR_W-1:0]            pwr_sum;
    logic [1:0][PWR_W-1:0]            peak_pwr;
    logic [1:0][BIN_W-1:0]            peak_bin;

    // Largest square is 2^30, so the signed product is always non-negative.
    function automatic logic [PWR_W-1:0] square(input logic signed [HALF_W-1:0] x);
        logic signed [PWR_W-1:0] p;
        p = x * x;
        return unsigned'(p);
    endfunction

    assign en            = !m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = en & (state_q == RUN) & !areset;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign at_last       = (bin_cnt == LAST_BIN);
    assign last_beat     = accept & (s_axis_tlast | at_last);
    assign trl_a_ld      = en & (state_q == DRAIN) & !vld_p1;
    assign trl_b_ld      = en & (state_q == TRL_B);
    assign frame_done    = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    assign beat_flags = {(s_axis_index != FFT_INDEX_LEN'(bin_cnt)),
                         at_last & !s_axis_tlast,
                         s_axis_tlast & !at_last};

    always_comb begin
        pwr_sum = '0;
        for (int c = 0; c < 2; c++) begin
            pwr_sum[c] = re_sq_p1[c] + im_sq_p1[c];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (last_beat) state_d = DRAIN;
            DRAIN:   if (trl_a_ld)  state_d = TRL_B;
            TRL_B:   if (en)        state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Frame bookkeeping: bin counter, status accumulation, peak search
    always_ff @(posedge aclk) begin
        if (areset) begin
            bin_cnt    <= '0;
            frame_cnt  <= '0;
            status_acc <= '0;
            peak_pwr   <= '0;
            peak_bin   <= '0;
        end else if (trl_b_ld) begin
            bin_cnt    <= '0;
            frame_cnt  <= frame_cnt + 16'd1;
            status_acc <= '0;
            peak_pwr   <= '0;
            peak_bin   <= '0;
        end else begin
            if (accept) begin
                bin_cnt    <= bin_cnt + 1'b1;
                status_acc <= status_acc | beat_flags;
            end
            if (en && vld_p1 && bin_p1 >= MIN_BIN) begin
                for (int c = 0; c < 2; c++) begin
                    if (pwr_sum[c] > peak_pwr[c]) begin
                        peak_pwr[c] <= pwr_sum[c];
                        peak_bin[c] <= bin_p1;
                    end
                end
            end
        end
    end

    // Stage 1: squares per channel
    always_ff @(posedge aclk) begin
        if (areset)  vld_p1 <= 1'b0;
        else if (en) vld_p1 <= accept;
    end

    always_ff @(posedge aclk) begin
        if (accept) begin
            for (int c = 0; c < 2; c++) begin
                re_sq_p1[c] <= square(s_axis_tdata[c*PWR_W +: HALF_W]);
                im_sq_p1[c] <= square(s_axis_tdata[c*PWR_W+HALF_W +: HALF_W]);
            end
            bin_p1 <= bin_cnt;
        end
    end

    // Stage 2: output register, shared by power beats and the two trailers
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_status  <= '0;
        end else begin
            if (frame_done) frame_status <= m_axis_tdata[34:32];
            if (trl_a_ld) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= {peak_pwr[1], peak_pwr[0]};
                m_axis_tuser  <= 1'b1;
                m_axis_tlast  <= 1'b0;
            end else if (trl_b_ld) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= {frame_cnt, 13'b0, status_acc,
                                  16'(peak_bin[1]), 16'(peak_bin[0])};
                m_axis_tuser  <= 1'b1;
                m_axis_tlast  <= 1'b1;
            end else if (en) begin
                m_axis_tvalid <= vld_p1;
                if (vld_p1) m_axis_tdata <= {pwr_sum[1], pwr_sum[0]};
                m_axis_tuser  <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_power_peak_reader.sv
// Randomized bench for fft_power_peak_reader: a beat-level reference model
// builds the expected output stream, which a per-cycle checker compares.
module tb_fft_power_peak_reader;
    localparam int LEN  = 16;
    localparam int PMIN = 1;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_index = '0;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready = 1'b1;
    logic        frame_done;
    logic [2:0]  frame_status;

    fft_power_peak_reader #(.FFT_LEN(LEN), .FFT_AXI_DATA_WIDTH(32),
                            .FFT_INDEX_LEN(32), .PEAK_MIN_BIN(PMIN)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .s_axis_index(s_axis_index),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .frame_done(frame_done), .frame_status(frame_status)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        tu;
        logic        tl;
        logic [63:0] d;
    } beat_t;

    beat_t       exp_q[$];
    logic [2:0]  exp_fstat = '0;
    int          m_cnt = 0;
    logic [2:0]  m_st = '0;
    logic [15:0] m_fc = '0;
    logic [31:0] m_p0[LEN];
    logic [31:0] m_p1[LEN];

    logic [63:0] cap_a = '0, cap_b = '0;
    logic [15:0] cap_fc[$];
    bit          rand_bp = 0;

    logic [15:0] sre0[LEN], sim0[LEN], sre1[LEN], sim1[LEN];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_pwr(input logic [15:0] re, input logic [15:0] im);
        longint r, i;
        r = longint'($signed(re));
        i = longint'($signed(im));
        return 32'(r * r + i * i);
    endfunction

    // Reference model: one call per accepted input beat
    task automatic model_accept(input logic [63:0] d, input logic [31:0] idx, input logic tl);
        logic [31:0] p0, p1, pk0, pk1;
        logic [15:0] pb0, pb1;
        bit          last;
        p0 = model_pwr(d[15:0], d[31:16]);
        p1 = model_pwr(d[47:32], d[63:48]);
        exp_q.push_back('{tu: 1'b0, tl: 1'b0, d: {p1, p0}});
        m_p0[m_cnt] = p0;
        m_p1[m_cnt] = p1;
        if (idx != 32'(m_cnt)) m_st[2] = 1'b1;
        if (tl && m_cnt != LEN - 1) m_st[0] = 1'b1;
        if (!tl && m_cnt == LEN - 1) m_st[1] = 1'b1;
        last = tl || (m_cnt == LEN - 1);
        m_cnt++;
        if (last) begin
            pk0 = 0; pk1 = 0; pb0 = 0; pb1 = 0;
            for (int b = PMIN; b < m_cnt; b++) begin
                if (m_p0[b] > pk0) begin pk0 = m_p0[b]; pb0 = 16'(b); end
                if (m_p1[b] > pk1) begin pk1 = m_p1[b]; pb1 = 16'(b); end
            end
            exp_q.push_back('{tu: 1'b1, tl: 1'b0, d: {pk1, pk0}});
            exp_q.push_back('{tu: 1'b1, tl: 1'b1, d: {m_fc, 13'b0, m_st, pb1, pb0}});
            m_fc++;
            m_cnt = 0;
            m_st = '0;
        end
    endtask

    always @(negedge aclk) m_axis_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;

    // Per-cycle output checker
    logic        prev_stall = 1'b0;
    logic [66:0] prev_out = '0;
    always begin
        beat_t e;
        logic  hs;
        @(negedge aclk);
        #2;
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_under_stall", {61'b0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata[63:0]} , {61'b0, prev_out[66:64], prev_out[63:0]});
            chk("frame_status", 64'(frame_status), 64'(exp_fstat));
            hs = m_axis_tvalid & m_axis_tready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got %h expected none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_axis_tdata, e.d);
                    chk("tlast", 64'(m_axis_tlast), 64'(e.tl));
                    chk("tuser", 64'(m_axis_tuser), 64'(e.tu));
                    chk("frame_done", 64'(frame_done), 64'(e.tl));
                    if (e.tu && !e.tl) cap_a = m_axis_tdata;
                    if (e.tl) begin
                        cap_b = m_axis_tdata;
                        cap_fc.push_back(m_axis_tdata[63:48]);
                        exp_fstat = e.d[34:32];
                    end
                end
            end else begin
                chk("frame_done_idle", 64'(frame_done), 64'd0);
            end
            prev_stall = m_axis_tvalid & !m_axis_tready;
            prev_out   = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [31:0] idx, input logic tl);
        int t = 0;
        s_axis_tdata  = d;
        s_axis_index  = idx;
        s_axis_tlast  = tl;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && t < 200) begin
            @(negedge aclk); #1; t++;
        end
        if (!s_axis_tready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got tready 0 expected 1");
        end else begin
            model_accept(d, idx, tl);
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int tlast_at, input int bad_bin,
                              input int bad_idx, input bit gaps);
        for (int b = 0; b < n; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge aclk);
            send_beat({sim1[b], sre1[b], sim0[b], sre0[b]},
                      (b == bad_bin) ? 32'(bad_idx) : 32'(b), b == tlast_at);
        end
    endtask

    task automatic fill_zero();
        for (int b = 0; b < LEN; b++) begin
            sre0[b] = '0; sim0[b] = '0; sre1[b] = '0; sim1[b] = '0;
        end
    endtask

    task automatic fill_rand();
        for (int b = 0; b < LEN; b++) begin
            sre0[b] = 16'($urandom); sim0[b] = 16'($urandom);
            sre1[b] = 16'($urandom); sim1[b] = 16'($urandom);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge aclk); t++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        m_cnt = 0; m_st = '0; m_fc = '0; exp_fstat = '0;
        repeat (2) @(negedge aclk);
        #1;
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_frame_status", 64'(frame_status), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("post_rst_tready", 64'(s_axis_tready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rdy  [1:4];
        logic [3:0] exp_tu   [1:4];
        do_reset();

        // Single tone on ch0 bin 5, with frame-end timing
        fill_zero();
        sre0[5] = 16'd1000;
        send_frame(LEN, LEN - 1, -1, 0, 0);
        exp_rdy = '{4'd0, 4'd0, 4'd0, 4'd1};
        exp_tu  = '{4'd0, 4'd0, 4'd1, 4'd1};
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("end_tready_T+%0d", k), 64'(s_axis_tready), 64'(exp_rdy[k]));
            if (k >= 2) begin
                chk($sformatf("end_tvalid_T+%0d", k), 64'(m_axis_tvalid), 64'd1);
                chk($sformatf("end_tuser_T+%0d", k), 64'(m_axis_tuser), 64'(exp_tu[k]));
                chk($sformatf("end_tlast_T+%0d", k), 64'(m_axis_tlast), 64'(k == 4));
                chk($sformatf("end_done_T+%0d", k), 64'(frame_done), 64'(k == 4));
            end
            @(negedge aclk);
        end
        wait_drain();
        chk("t1_trailer_a", cap_a, {32'd0, 32'd1000000});
        chk("t1_trailer_b", cap_b, 64'd5);

        // Full-scale bin, ignored DC bin, tied peaks
        fill_zero();
        sre0[0] = 16'h8000; sim0[0] = 16'h8000;
        sre0[3] = 16'h8000; sim0[3] = 16'h8000;
        sre1[0] = 16'd30000;
        sre1[4] = 16'd1000; sim1[4] = 16'd1000;
        sre1[9] = 16'd1000; sim1[9] = 16'd1000;
        send_frame(LEN, LEN - 1, -1, 0, 0);
        wait_drain();
        chk("t2_trailer_a", cap_a, {32'd2000000, 32'h80000000});
        chk("t2_trailer_b", cap_b, {16'd1, 13'd0, 3'b000, 16'd4, 16'd3});

        // Early tlast, missing tlast, clean frame, index mismatch
        fill_rand();
        send_frame(11, 10, -1, 0, 0);
        wait_drain();
        chk("early_tlast_status", 64'(cap_b[34:32]), 64'(3'b001));
        chk("early_tlast_fstat", 64'(frame_status), 64'(3'b001));
        fill_rand();
        send_frame(LEN, -1, -1, 0, 0);
        wait_drain();
        chk("missing_tlast_status", 64'(cap_b[34:32]), 64'(3'b010));
        fill_rand();
        send_frame(LEN, LEN - 1, -1, 0, 0);
        wait_drain();
        chk("clean_status", 64'(cap_b[34:32]), 64'd0);
        chk("clean_fc", 64'(cap_b[63:48]), 64'd4);
        fill_rand();
        send_frame(LEN, LEN - 1, 6, 7, 0);
        wait_drain();
        chk("index_status", 64'(cap_b[34:32]), 64'(3'b100));

        // Three back-to-back random frames under random backpressure
        do_reset();
        cap_fc.delete();
        rand_bp = 1;
        for (int f = 0; f < 3; f++) begin
            fill_rand();
            send_frame(LEN, LEN - 1, -1, 0, 1);
        end
        wait_drain();
        rand_bp = 0;
        chk("rnd_fc_count", 64'(cap_fc.size()), 64'd3);
        if (cap_fc.size() == 3) begin
            chk("rnd_fc0", 64'(cap_fc[0]), 64'd0);
            chk("rnd_fc1", 64'(cap_fc[1]), 64'd1);
            chk("rnd_fc2", 64'(cap_fc[2]), 64'd2);
        end

        // Reset in the middle of a frame, then a clean frame from bin 0
        repeat (3) @(negedge aclk);
        fill_rand();
        send_frame(8, -1, -1, 0, 0);
        do_reset();
        fill_zero();
        sre0[5] = 16'd1000;
        send_frame(LEN, LEN - 1, -1, 0, 0);
        wait_drain();
        chk("after_rst_trailer_a", cap_a, {32'd0, 32'd1000000});
        chk("after_rst_trailer_b", cap_b, 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_power_peak_reader.md
# fft_power_peak_reader

Consumer for the FFT DSP result stream. Accepts per-bin complex FFT output (two channels, with bin index), converts each bin to power |X|², tracks the peak bin per channel, and forwards power words downstream. Each frame ends with a two-beat trailer carrying peak, frame-count and integrity-status information. Sits between the FFT DSP output and the capture/Ethernet packetizer.

## Interface
- FFT_LEN, 8192, bins per frame (power of 2, 16..65536)
- FFT_AXI_DATA_WIDTH, 32, per-channel input width; fixed at 32: {im[31:16], re[15:0]}, signed
- FFT_INDEX_LEN, 32, width of s_axis_index
- PEAK_MIN_BIN, 1, lowest bin eligible for peak search (skips DC)

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active high
- s_axis_tdata  in  64  ch1 in [63:32], ch0 in [31:0]
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  last bin of frame
- s_axis_tready  out  1  input accept
- s_axis_index  in  FFT_INDEX_LEN  bin index of current beat
- m_axis_tdata  out  64  ch1 power [63:32], ch0 power [31:0]; or trailer
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  high only on trailer beat B
- m_axis_tuser  out  1  1 on trailer beats, 0 on power beats
- m_axis_tready  in  1  downstream accept
- frame_done  out  1  one-cycle pulse when trailer B is accepted downstream
- frame_status  out  3  status of last completed frame, held until next frame_done

## Operation
- Power per channel: P = re² + im², unsigned 32 bit. Max 2³¹ at re = im = −32768; no saturation needed.
- Two-stage pipeline:
  - S1 registers re² and im² per channel.
  - S2 (output register) registers the sum.
  - Global advance enable en = !m_axis_tvalid | m_axis_tready. All stages hold when en = 0.
- s_axis_tready = en & (state == RUN).
- bin_cnt counts accepted beats from 0. Reset to 0 after each frame.
- Integrity checks on every accepted beat:
  - s_axis_index != bin_cnt → status bit2 (index_mismatch).
  - tlast with bin_cnt != FFT_LEN−1 → bit0 (tlast_unexpected); frame ends.
  - bin_cnt == FFT_LEN−1 without tlast → bit1 (tlast_missing); beat is treated as last and the frame ends.
- Peak tracking:
  - Per channel: peak_pwr and peak_bin, updated when a power beat loads S2 with bin ≥ PEAK_MIN_BIN and P > peak_pwr (strict, so ties keep the lowest bin).
  - Cleared to 0 at frame start.
- State machine:
  - RUN: accept beats. On the last beat accepted → DRAIN.
  - DRAIN: wait until S1 is empty and en = 1. Then load trailer A into S2 → TRL_B.
  - TRL_B: when en = 1, load trailer B into S2 → RUN. At this point clear peaks and bin_cnt, and increment frame_cnt (16 bit, wraps).
- Trailer A tdata: {ch1 peak_pwr, ch0 peak_pwr}.
- Trailer B tdata: {frame_cnt[15:0], 13'b0, status[2:0], ch1 peak_bin[15:0], ch0 peak_bin[15:0]}.
- frame_done and frame_status update when trailer B handshakes on m_axis.
- Reset mid-frame:
  - All pipeline contents discarded.
  - state = RUN, bin_cnt = 0, frame_cnt = 0, peaks = 0.
  - The next accepted beat is bin 0.

## Timing
- Reset values: s_axis_tready 1 (after reset deasserts; 0 while areset is high), m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, m_axis_tuser 0, frame_done 0, frame_status 0.
- Latency: a beat accepted in cycle N appears on m_axis at N+2 with no stall.
- Frame end (last beat accepted at T, m_axis_tready held high):
  - Last power beat on output at T+2.
  - Trailer A at T+3; trailer B at T+4; frame_done pulses at T+4.
  - s_axis_tready low T+1..T+3, high again at T+4. Minimum 3-cycle input gap between frames.
- Backpressure: m_axis_tvalid/tdata/tlast/tuser are stable while tvalid=1 and tready=0. No beat is lost or duplicated.
- s_axis_tvalid may toggle freely. Only cycles with tvalid & tready advance bin_cnt.

## Test plan
- FFT_LEN=16, ch0 bin5 = {im 0, re 1000}, all other bins 0, no stalls → 16 power beats (bin5 = 1000000), trailer A ch0 = 1000000, trailer B ch0 peak_bin 5, status 0, tlast on beat 18 only, frame_done at T+4.
- Max magnitude: re = im = −32768 on bin 3 → P = 0x80000000 exactly; bin 0 at larger magnitude is ignored (PEAK_MIN_BIN = 1); two equal peaks at bins 4 and 9 → peak_bin 4.
- Random m_axis_tready (50%) over 3 back-to-back frames → output sequence matches the golden model exactly; frame_cnt in trailer B reads 0, 1, 2.
- tlast at bin 10 of 16 → frame ends, status = 3'b001; missing tlast at bin 15 → status = 3'b010; the following frame is clean with status 0.
- Index 7 presented at bin_cnt 6 → status bit2 set; assert areset mid-frame at bin 8 → outputs return to reset values, and the next frame starts at bin 0 with frame_cnt 0.
